// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and stream constants
// for the program loader (LOADER_CHECKSUM_EN selects the CKSUM stage).
package program_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CKSUM,
    DONE,
    ERROR
  } state_e;

  // States in which the loader consumes stream bytes and holds the core.
  function automatic logic is_busy(state_e s);
    return (s == HDR_LO) || (s == HDR_HI) ||
           (s == DATA)   || (s == CKSUM);
  endfunction

endpackage

// File: rtl/program_loader_assembler.sv
// byte_word_assembler: packs 4 accepted bytes LSB-first into a word.
// Ports: clk, reset, clear, byte_valid_i/byte_i in; last_byte_o, word_valid_o (1-cycle), word_o out.
module byte_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] word_q, word_d;
  logic        wv_q, wv_d;

  assign last_byte_o  = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid_o = wv_q;
  assign word_o       = word_q;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    word_d = word_q;
    wv_d   = 1'b0;
    if (clear) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_valid_i) begin
      // Shift right so byte 0 ends up in [7:0] after four bytes.
      sh_d  = {byte_i, sh_q[31:8]};
      cnt_d = cnt_q + 2'd1;
      if (last_byte_o) begin
        wv_d   = 1'b1;
        word_d = {byte_i, sh_q[31:8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: byte stream (N lo, N hi, 4N data bytes [, xor]) -> program RAM writes.
// Ports: clk, reset, Start_i, Byte_i/Byte_Valid_i/Byte_Ready_o, Mem_We_o/Addr/Data,
//        Cpu_Hold_o, Done_o, Error_o. Macro LOADER_CHECKSUM_EN adds a trailing xor byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  output logic                  Mem_We_o,
  output logic [31:0]           Mem_Addr_o,
  output logic [DATA_WIDTH-1:0] Mem_Data_o,
  output logic                  Cpu_Hold_o,
  output logic                  Done_o,
  output logic                  Error_o
);

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  n_lo_q, n_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        hs;
  logic        start_ok;
  logic        asm_valid;
  logic        last_byte;
  logic        word_valid;
  logic [31:0] word;

  // Ready is a flop, so hs never loops Valid back into Ready.
  assign hs        = Byte_Valid_i & busy_q;
  assign start_ok  = Start_i & ~busy_q;
  assign asm_valid = hs & (state_q == DATA);

  byte_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .byte_valid_i (asm_valid),
    .byte_i       (Byte_i),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    n_lo_d  = n_lo_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    if (word_valid) addr_d = addr_q + 32'd4;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start_i) begin
          state_d = HDR_LO;
          wcnt_d  = '0;
          addr_d  = BASE_ADDRESS;
        end
      end
      HDR_LO: begin
        if (hs) begin
          n_lo_d  = Byte_i;
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (hs) begin
          n_d = {Byte_i, n_lo_q};
          if (n_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CKSUM;
`else
            state_d = DONE;
`endif
          end else if (n_d > 16'(MEMORY_DEPTH)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (hs && last_byte) begin
          wcnt_d = wcnt_q + 16'd1;
          if (wcnt_q == n_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CKSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
      CKSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (hs) state_d = (Byte_i == csum_q) ? DONE : ERROR;
`else
        state_d = IDLE;
`endif
      end
    endcase
    busy_d = is_busy(state_d);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERROR);
  end

`ifdef LOADER_CHECKSUM_EN
  always_comb begin
    csum_d = csum_q;
    if (start_ok)       csum_d = '0;
    else if (asm_valid) csum_d = csum_q ^ Byte_i;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      n_lo_q  <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      addr_q  <= BASE_ADDRESS;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      n_lo_q  <= n_lo_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
    end
  end

  assign Byte_Ready_o = busy_q;
  assign Cpu_Hold_o   = busy_q;
  assign Done_o       = done_q;
  assign Error_o      = err_q;
  assign Mem_We_o     = word_valid;
  assign Mem_Addr_o   = addr_q;
  assign Mem_Data_o   = word;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed streams, write scoreboard with a negedge monitor.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic [7:0]  Byte_i;
  logic        Byte_Valid_i;
  logic        Byte_Ready_o;
  logic        Mem_We_o;
  logic [31:0] Mem_Addr_o;
  logic [31:0] Mem_Data_o;
  logic        Cpu_Hold_o;
  logic        Done_o;
  logic        Error_o;

  int compared   = 0;
  int mismatched = 0;
  int we_count   = 0;
  int w0;

  logic [63:0] exp_q[$];
  logic [31:0] wbuf[64];

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .Start_i      (Start_i),
    .Byte_i       (Byte_i),
    .Byte_Valid_i (Byte_Valid_i),
    .Byte_Ready_o (Byte_Ready_o),
    .Mem_We_o     (Mem_We_o),
    .Mem_Addr_o   (Mem_Addr_o),
    .Mem_Data_o   (Mem_Data_o),
    .Cpu_Hold_o   (Cpu_Hold_o),
    .Done_o       (Done_o),
    .Error_o      (Error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (Mem_We_o === 1'b1) begin
        logic [63:0] e;
        we_count++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_write: got %h@%h want none",
                   Mem_Data_o, Mem_Addr_o);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", Mem_Addr_o, e[63:32]);
          check("wr_data", Mem_Data_o, e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    Byte_i       = b;
    Byte_Valid_i = 1'b1;
    @(negedge clk);
    while (Byte_Ready_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      compared++;
      mismatched++;
      $display("FAIL byte_timeout: got ready 0 want 1");
    end
    @(posedge clk);
    #1;
    Byte_Valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    Start_i = 1'b1;
    @(posedge clk);
    #1;
    Start_i = 1'b0;
  endtask

  task automatic push_word(input int i, input logic [31:0] w);
    exp_q.push_back({BASE + 32'(4 * i), w});
  endtask

  task automatic load_stream(input int n, input int maxgap);
    logic [7:0] b;
    logic [15:0] nn;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    nn = 16'(n);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = wbuf[i][8*k +: 8];
`ifdef LOADER_CHECKSUM_EN
        x = x ^ b;
`endif
        if (k == 3) push_word(i, wbuf[i]);
        if (maxgap > 0) idle($urandom_range(0, maxgap));
        send_byte(b);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  initial begin
    reset        = 1'b1;
    Start_i      = 1'b0;
    Byte_Valid_i = 1'b0;
    Byte_i       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(Byte_Ready_o), 0);
    check("rst_we", 32'(Mem_We_o), 0);
    check("rst_addr", Mem_Addr_o, BASE);
    check("rst_data", Mem_Data_o, 0);
    check("rst_hold", 32'(Cpu_Hold_o), 0);
    check("rst_done", 32'(Done_o), 0);
    check("rst_err", 32'(Error_o), 0);
    reset = 1'b0;
    idle(1);

    // Two-word program.
    wbuf[0] = 32'h00A0_0513;
    wbuf[1] = 32'h0010_0593;
    w0 = we_count;
    pulse_start();
    check("t1_hold_on", 32'(Cpu_Hold_o), 1);
    check("t1_ready", 32'(Byte_Ready_o), 1);
    load_stream(2, 0);
    check("t1_done", 32'(Done_o), 1);
    check("t1_hold_off", 32'(Cpu_Hold_o), 0);
    check("t1_err", 32'(Error_o), 0);
    idle(3);
    check("t1_we_cnt", 32'(we_count - w0), 2);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // N = 33 rejected.
    w0 = we_count;
    pulse_start();
    check("t2_done_clr", 32'(Done_o), 0);
    send_byte(8'h21);
    send_byte(8'h00);
    check("t2_err", 32'(Error_o), 1);
    check("t2_hold", 32'(Cpu_Hold_o), 0);
    idle(3);
    check("t2_ready", 32'(Byte_Ready_o), 0);
    check("t2_we_cnt", 32'(we_count - w0), 0);

    // N = 32 with idle gaps.
    for (int i = 0; i < 32; i++)
      wbuf[i] = {8'(i), 8'(8'hC3 ^ 8'(i)), 8'h5A, 8'(3 * i)};
    w0 = we_count;
    pulse_start();
    check("t3_err_clr", 32'(Error_o), 0);
    load_stream(32, 5);
    check("t3_done", 32'(Done_o), 1);
    idle(3);
    check("t3_we_cnt", 32'(we_count - w0), 32);
    check("t3_q_empty", 32'(exp_q.size()), 0);

    // Reset after the 6th data byte of N = 4.
    wbuf[0] = 32'h1234_5678;
    wbuf[1] = 32'h9ABC_DEF0;
    wbuf[2] = 32'h0000_0013;
    wbuf[3] = 32'hFFFF_FFFF;
    w0 = we_count;
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h00);
    push_word(0, wbuf[0]);
    for (int k = 0; k < 4; k++) send_byte(wbuf[0][8*k +: 8]);
    send_byte(wbuf[1][7:0]);
    send_byte(wbuf[1][15:8]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t4_ready", 32'(Byte_Ready_o), 0);
    check("t4_hold", 32'(Cpu_Hold_o), 0);
    check("t4_we", 32'(Mem_We_o), 0);
    check("t4_addr", Mem_Addr_o, BASE);
    check("t4_data", Mem_Data_o, 0);
    check("t4_done", 32'(Done_o), 0);
    check("t4_err", 32'(Error_o), 0);
    check("t4_we_cnt", 32'(we_count - w0), 1);
    reset = 1'b0;
    w0 = we_count;
    pulse_start();
    load_stream(4, 1);
    check("t4_done2", 32'(Done_o), 1);
    idle(3);
    check("t4_we_cnt2", 32'(we_count - w0), 4);
    check("t4_q_empty", 32'(exp_q.size()), 0);

    // Empty program, then Start with a byte in the same cycle.
    w0 = we_count;
    pulse_start();
    load_stream(0, 0);
    check("t5_done", 32'(Done_o), 1);
    check("t5_hold", 32'(Cpu_Hold_o), 0);
    idle(3);
    check("t5_we_cnt", 32'(we_count - w0), 0);
    Start_i      = 1'b1;
    Byte_Valid_i = 1'b1;
    Byte_i       = 8'h05;
    @(posedge clk);
    #1;
    Start_i      = 1'b0;
    Byte_Valid_i = 1'b0;
    check("t5_restart", 32'(Cpu_Hold_o), 1);
    check("t5_done_clr", 32'(Done_o), 0);
    wbuf[0] = 32'hDEAD_BEEF;
    w0 = we_count;
    load_stream(1, 0);
    check("t5_done2", 32'(Done_o), 1);
    idle(3);
    check("t5_we_cnt2", 32'(we_count - w0), 1);
    check("t5_q_empty", 32'(exp_q.size()), 0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum 11^22^33^44 = 44.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    push_word(0, 32'h4433_2211);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h44);
    check("t6_done", 32'(Done_o), 1);
    check("t6_err", 32'(Error_o), 0);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    push_word(0, 32'h4433_2211);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h45);
    check("t6_err2", 32'(Error_o), 1);
    check("t6_done2", 32'(Done_o), 0);
    idle(3);
    check("t6_q_empty", 32'(exp_q.size()), 0);
`endif

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
